// File: rtl/mvm_pkg.sv
// mvm_pkg: shared types and sizing helpers for the matrix-vector engine
package mvm_pkg;
  typedef enum logic [1:0] {LOAD, RUN, RESULT} state_t;
  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH = 24;
  function automatic int acc_min_w(input int dw, input int cols);
    return 2 * dw + $clog2(cols);
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mat_vec_engine_mac_lane.sv
// mac_lane: one multiply-accumulate lane, wrapping modulo 2^ACC_WIDTH
//   en          accumulate a*b this cycle
//   clr         zero the accumulator (wins over en)
//   signed_mode sign-extend a and b, otherwise zero-extend
//   acc         running sum
module mac_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);
  logic [ACC_WIDTH-1:0] ax, bx;
  assign ax = {{(ACC_WIDTH-DATA_WIDTH){signed_mode & a[DATA_WIDTH-1]}}, a};
  assign bx = {{(ACC_WIDTH-DATA_WIDTH){signed_mode & b[DATA_WIDTH-1]}}, b};
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + ax * bx;
endmodule

// File: rtl/mat_vec_engine.sv
// mat_vec_engine: y = A*x with a row-skewed MAC array and valid/ready result port
//   a_valid/a_ready/a_data  one column of A per beat, lane i = row i
//   b_valid/b_ready/b_data  one element of x per beat, index 0 first
//   signed_mode, acc_en     sampled on the edge that starts a job
//   clr                     accumulator clear, only acted on while loading
//   busy                    computing or holding results
//   res_valid/res_ready/res_data  all ROWS results at once, lane i = y[i]
module mat_vec_engine
  import mvm_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [DATA_WIDTH-1:0]      b_data,
  input  logic                       signed_mode,
  input  logic                       acc_en,
  input  logic                       clr,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ROWS*ACC_WIDTH-1:0]  res_data
);
  localparam int CW = cnt_w(COLS);
  localparam int KW = cnt_w(COLS + ROWS - 2);
  localparam int IW = idx_w(COLS);
  localparam logic [CW-1:0] CFULL = CW'(COLS);
  localparam logic [KW-1:0] KLAST = KW'(COLS + ROWS - 2);
  state_t state, nxt;
  logic [CW-1:0] a_cnt, b_cnt;
  logic [KW-1:0] k;
  logic sm_q, start, last, hs, a_fire, b_fire, acc_clr;
  logic [DATA_WIDTH-1:0] a_buf [COLS][ROWS];
  logic [DATA_WIDTH-1:0] x_buf [COLS];
  logic [DATA_WIDTH-1:0] x_cur;
  logic [DATA_WIDTH-1:0] skew [1:ROWS-1];
  assign a_ready = state == LOAD && a_cnt < CFULL;
  assign b_ready = state == LOAD && b_cnt < CFULL;
  assign busy = state != LOAD;
  assign res_valid = state == RESULT;
  assign a_fire = a_valid & a_ready;
  assign b_fire = b_valid & b_ready;
  assign start = state == LOAD && a_cnt == CFULL && b_cnt == CFULL;
  assign last = state == RUN && k == KLAST;
  assign hs = state == RESULT && res_ready;
  // acc_en only matters on the start edge, so it is used directly there
  assign acc_clr = (state == LOAD && clr) || (start && !acc_en);
  // head of the skew chain: x[k] while it exists, zero once x is exhausted
  assign x_cur = k < KW'(COLS) ? x_buf[k[IW-1:0]] : '0;
  always_comb begin
    nxt = state;
    nxt = start ? RUN : last ? RESULT : hs ? LOAD : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LOAD;
      a_cnt <= '0;
      b_cnt <= '0;
      k <= '0;
      sm_q <= 1'b0;
    end else begin
      state <= nxt;
      k <= state == RUN ? k + 1'b1 : '0;
      a_cnt <= hs ? '0 : a_cnt + CW'(a_fire);
      b_cnt <= hs ? '0 : b_cnt + CW'(b_fire);
      if (start) sm_q <= signed_mode;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int j = 0; j < COLS; j++) begin
        x_buf[j] <= '0;
        for (int r = 0; r < ROWS; r++) a_buf[j][r] <= '0;
      end
    end else begin
      if (a_fire)
        for (int r = 0; r < ROWS; r++) a_buf[a_cnt[IW-1:0]][r] <= a_data[r*DATA_WIDTH +: DATA_WIDTH];
      if (b_fire) x_buf[b_cnt[IW-1:0]] <= b_data;
    end
  // skew[i] holds x[k-i], so lane i sees its element i cycles after lane 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 1; i < ROWS; i++) skew[i] <= '0;
    end else begin
      skew[1] <= x_cur;
      for (int i = 2; i < ROWS; i++) skew[i] <= skew[i-1];
    end
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [KW-1:0] kd;
    logic en;
    logic [DATA_WIDTH-1:0] b_in;
    assign kd = k - KW'(i);
    assign en = state == RUN && k >= KW'(i) && kd < KW'(COLS);
    if (i == 0) begin : g_head
      assign b_in = x_cur;
    end else begin : g_tap
      assign b_in = skew[i];
    end
    mac_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk(clk),
      .rst(rst),
      .en(en),
      .clr(acc_clr),
      .signed_mode(sm_q),
      .a(a_buf[kd[IW-1:0]][i]),
      .b(b_in),
      .acc(res_data[i*ACC_WIDTH +: ACC_WIDTH])
    );
  end
endmodule

// File: tb/tb_mat_vec_engine.sv
// tb_mat_vec_engine: randomized scoreboard bench for mat_vec_engine
module tb_mat_vec_engine;
  localparam int R = 8;
  localparam int C = 8;
  localparam int DW = 8;
  localparam int AW = 16;
  typedef logic [R*AW-1:0] vec_t;
  logic clk = 0, rst = 1;
  logic a_valid = 0, a_ready, b_valid = 0, b_ready;
  logic [R*DW-1:0] a_data = '0;
  logic [DW-1:0] b_data = '0;
  logic signed_mode = 0, acc_en = 0, clr = 0, busy, res_valid, res_ready = 1;
  vec_t res_data;
  int checks = 0, errors = 0, rdy_mode = 0;
  vec_t exp_q[$];
  logic [AW-1:0] mdl [R];
  logic [DW-1:0] ma [R][C];
  logic [DW-1:0] mx [C];
  vec_t held;
  bit stall = 0;
  mat_vec_engine #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .signed_mode(signed_mode),
    .acc_en(acc_en), .clr(clr), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic longint ext(input logic [DW-1:0] v, input bit sm);
    return sm ? longint'($signed(v)) : longint'(v);
  endfunction
  task automatic model_job(input bit sm, input bit ae);
    vec_t v;
    if (!ae) foreach (mdl[i]) mdl[i] = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) mdl[i] = mdl[i] + AW'(ext(ma[i][j], sm) * ext(mx[j], sm));
    for (int i = 0; i < R; i++) v[i*AW +: AW] = mdl[i];
    exp_q.push_back(v);
  endtask
  task automatic fill(input int av, input int xv, input bit ramp, input bit rnd);
    for (int j = 0; j < C; j++) begin
      mx[j] = rnd ? DW'($urandom) : ramp ? DW'(j + 1) : DW'(xv);
      for (int i = 0; i < R; i++) ma[i][j] = rnd ? DW'($urandom) : DW'(av);
    end
  endtask
  task automatic load_job(input bit sm, input bit ae, input int a_delay, input int gap);
    int ai = 0, bi = 0, n = 0;
    signed_mode = sm;
    acc_en = ae;
    model_job(sm, ae);
    while ((ai < C || bi < C) && n < 400) begin
      @(negedge clk);
      n++;
      a_valid = 0;
      b_valid = 0;
      if (ai == C) begin
        a_valid = 1;
        a_data = {$urandom, $urandom};
        chk("a_extra_ready", vec_t'(a_ready), 0);
      end else if (n > a_delay && $urandom_range(0, 99) >= gap) begin
        a_valid = 1;
        for (int r = 0; r < R; r++) a_data[r*DW +: DW] = ma[r][ai];
        if (a_ready) ai++;
      end
      if (bi == C) begin
        b_valid = 1;
        b_data = DW'($urandom);
        chk("b_extra_ready", vec_t'(b_ready), 0);
      end else if ($urandom_range(0, 99) >= gap) begin
        b_valid = 1;
        b_data = mx[bi];
        if (b_ready) bi++;
      end
    end
    if (n >= 400) chk("load_timeout", vec_t'(n), 0);
    @(negedge clk);
    a_valid = 0;
    b_valid = 0;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("job_start", vec_t'(busy), 1);
    signed_mode = 1'($urandom);
    acc_en = 1'($urandom);
  endtask
  task automatic do_clr();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("clr_in_load", vec_t'(busy), 0);
    clr = 1;
    foreach (mdl[i]) mdl[i] = '0;
    @(negedge clk);
    clr = 0;
  endtask
  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("res_wait", vec_t'(res_valid), 1);
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", vec_t'(exp_q.size()), 0);
  endtask
  always @(negedge clk) begin
    vec_t e;
    res_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom);
    if (stall) begin
      chk("stall_valid", vec_t'(res_valid), 1);
      chk("stall_data", res_data, held);
    end
    stall = 0;
    if (res_valid) begin
      chk("result_readies", vec_t'({a_ready, b_ready}), 0);
      if (res_ready) begin
        if (exp_q.size() == 0) chk("res_unexpected", vec_t'(res_valid), 0);
        else begin
          e = exp_q.pop_front();
          chk("res_data", res_data, e);
        end
      end else begin
        stall = 1;
        held = res_data;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int cnt;
    foreach (mdl[i]) mdl[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_ready", vec_t'(a_ready), 1);
    chk("rst_b_ready", vec_t'(b_ready), 1);
    chk("rst_busy", vec_t'(busy), 0);
    chk("rst_res_valid", vec_t'(res_valid), 0);
    chk("rst_res_data", res_data, 0);
    rst = 0;
    fill(1, 0, 1, 0);
    load_job(0, 0, 0, 0);
    cnt = 0;
    while (!res_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("run_latency", vec_t'(cnt), C + R - 1);
    fill(8'hFF, 2, 0, 0);
    load_job(1, 0, 0, 20);
    load_job(0, 0, 0, 20);
    drain();
    @(posedge clk);
    rdy_mode = 2;
    fill(1, 0, 1, 0);
    load_job(0, 0, 0, 0);
    wait_res();
    repeat (10) @(negedge clk);
    @(posedge clk);
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_load_a_ready", vec_t'(a_ready), 1);
    chk("bp_load_res_valid", vec_t'(res_valid), 0);
    load_job(0, 1, 0, 0);
    do_clr();
    load_job(0, 1, 0, 0);
    fill(8'hFF, 8'hFF, 0, 0);
    load_job(0, 0, C + 4, 0);
    drain();
    @(posedge clk);
    rdy_mode = 1;
    for (int t = 0; t < 20; t++) begin
      fill(0, 0, 0, 1);
      if ($urandom_range(0, 3) == 0) do_clr();
      load_job(1'($urandom), 1'($urandom), $urandom_range(0, 3), 30);
    end
    drain();
    @(posedge clk);
    rdy_mode = 0;
    fill(1, 0, 1, 0);
    load_job(0, 1, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_busy", vec_t'(busy), 0);
    chk("abort_res_valid", vec_t'(res_valid), 0);
    chk("abort_a_ready", vec_t'(a_ready), 1);
    chk("abort_b_ready", vec_t'(b_ready), 1);
    chk("abort_res_data", res_data, 0);
    void'(exp_q.pop_back());
    foreach (mdl[i]) mdl[i] = '0;
    @(negedge clk);
    rst = 0;
    load_job(0, 1, 0, 0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
